// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline widths, constants and fetch-queue entry type
package pipeline_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Forwarding mux selects used by the execute stage.
  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order fetch queue with separate alloc, fill and pop pointers
module fetch_buffer import pipeline_pkg::*; #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              alloc,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              fill,
  input  logic [31:0]       fill_instr,
  input  logic              pop,
  output logic [AW:0]       count,
  output logic [AW:0]       unfilled,
  output fetch_entry_t      head,
  output logic              head_ready
);

  fetch_entry_t entries [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  fill_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_alloc;
  logic         do_fill;
  logic         do_pop;

  assign do_alloc   = alloc && !clear;
  assign do_fill    = fill  && !clear;
  assign do_pop     = pop   && !clear;
  assign count      = wr_ptr - rd_ptr;
  assign unfilled   = wr_ptr - fill_ptr;
  assign head       = entries[rd_ptr[AW-1:0]];
  assign head_ready = (count != '0) && head.filled;

  // Pointer update; clear abandons every entry, including ones still awaiting a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else begin
      if (do_alloc) wr_ptr   <= wr_ptr + 1'b1;
      if (do_fill)  fill_ptr <= fill_ptr + 1'b1;
      if (do_pop)   rd_ptr   <= rd_ptr + 1'b1;
    end
  end

  // Entry payload; no reset needed because an entry is only read after alloc has written it.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entries[wr_ptr[AW-1:0]] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
    end
    if (do_fill) begin
      entries[fill_ptr[AW-1:0]].instr  <= fill_instr;
      entries[fill_ptr[AW-1:0]].filled <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID register; FETCH_PERF_EN adds stall/flush/bubble counters
module fetch_stage #(
  parameter int unsigned     XLEN      = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2,
  parameter logic [31:0]     NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall_in,
  input  logic            Flush_in,
  input  logic [XLEN-1:0] Redirect_pc_in,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            IF_ID_valid,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned DW = AW + 3;

  logic [XLEN-1:0]            pc;
  logic [DW-1:0]              drop_cnt;
  logic [DW-1:0]              pending;
  logic [AW:0]                count;
  logic [AW:0]                unfilled;
  pipeline_pkg::fetch_entry_t head;
  logic                       head_ready;
  logic                       accept;
  logic                       fill;
  logic                       pop;

  assign imem_req_valid = rst_n && !Flush_in && (32'(count) < BUF_DEPTH);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  // Responses still owed to us: stale ones from earlier flushes plus live unfilled entries.
  assign pending        = drop_cnt + DW'(unfilled);
  assign fill           = imem_rsp_valid && !Flush_in && (drop_cnt == '0) && (unfilled != '0);
  assign pop            = !Flush_in && !Stall_in && head_ready;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (Flush_in),
    .alloc      (accept),
    .alloc_pc   (pc),
    .fill       (fill),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .count      (count),
    .unfilled   (unfilled),
    .head       (head),
    .head_ready (head_ready)
  );

  // PC: redirect on flush, otherwise advance by one instruction per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= RESET_PC;
    else if (Flush_in) pc <= Redirect_pc_in;
    else if (accept)   pc <= pc + XLEN'(4);
  end

  // Stale-response counter; a repeated flush keeps what was still owed from the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (Flush_in) begin
      drop_cnt <= (imem_rsp_valid && (pending != '0)) ? pending - DW'(1) : pending;
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // IF/ID register: flush beats stall, stall holds, otherwise load the head or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_valid <= 1'b0;
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP_INSTR;
    end else if (Flush_in) begin
      IF_ID_valid <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
    end else if (Stall_in) begin
      IF_ID_valid <= IF_ID_valid;
    end else if (head_ready) begin
      IF_ID_valid <= 1'b1;
      IF_ID_pc    <= head.pc;
      IF_ID_instr <= head.instr;
    end else begin
      IF_ID_valid <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running event counters; they wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (Stall_in) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (Flush_in) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (!Flush_in && !Stall_in && !head_ready) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

  // A response with nothing owed is ignored by the datapath and flagged here.
  assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (pending != '0));

endmodule
